framebuffer_writer: RTL
=======================

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8; pixel FIFO entries; power of two, at least 4.
REQ-002 Parameter FB_PIXELS, default 256000; framebuffer size (640 x 400); valid addresses are 0..FB_PIXELS-1.
REQ-003 Parameter CLEAR_COLOR, default 16'h0000; background color written by frame clear.
REQ-004 I_CLOCK  in  1  single clock; all state updates on the rising edge.
REQ-005 I_RESET  in  1  reset, synchronous, active-high.
REQ-006 I_LOCK  in  1  enable; when low, all state, FIFO and counters hold; I_RESET still acts.
REQ-007 I_FRAMESTALL  in  1  frame-in-progress flag from the rasterizer.
REQ-008 I_PIXVALID  in  1  pixel write request this cycle.
REQ-009 I_ADDR  in  18  pixel address, row*640+column.
REQ-010 I_COLOR  in  16  pixel color.
REQ-011 O_STALL  out  1  backpressure to the rasterizer.
REQ-012 O_SRAM_ADDR  out  18  framebuffer write address.
REQ-013 O_SRAM_DATA  out  16  framebuffer write data.
REQ-014 O_SRAM_WE  out  1  write valid.
REQ-015 I_SRAM_READY  in  1  memory accepts the presented write this cycle.
REQ-016 O_FRAMEDONE  out  1  one-cycle pulse when a frame is fully written.
REQ-017 O_DROPCOUNT  out  16  count of discarded pixels in the current frame.

Function
REQ-018 States SHALL be IDLE, CLEAR, RUN, FLUSH and DONE.
REQ-019 IDLE->CLEAR (FB_CLEAR_EN defined) or IDLE->RUN (undefined) SHALL occur on a sampled 0->1 transition of I_FRAMESTALL; O_DROPCOUNT clears on the same edge.
REQ-020 CLEAR SHALL step an address counter 0..FB_PIXELS-1 with O_SRAM_WE=1 and O_SRAM_DATA=CLEAR_COLOR; the counter advances only on cycles with I_SRAM_READY=1; CLEAR->RUN after address FB_PIXELS-1 is accepted.
REQ-021 RUN: a pixel SHALL be pushed when I_PIXVALID=1, O_STALL=0 and I_ADDR<FB_PIXELS.
REQ-022 A pixel with I_ADDR>=FB_PIXELS, or with I_PIXVALID=1 in IDLE, CLEAR, FLUSH or DONE, SHALL be discarded and increment O_DROPCOUNT, which saturates at 16'hFFFF.
REQ-023 O_STALL SHALL be 1 in CLEAR, FLUSH and DONE, and in RUN when FIFO count >= FIFO_DEPTH-1; it is 0 in IDLE and otherwise. The free slot absorbs one late push from the negedge-driven source.
REQ-024 The FIFO SHALL be first-word-fall-through: O_SRAM_WE=1 whenever it is non-empty (outside CLEAR), with O_SRAM_ADDR/O_SRAM_DATA equal to the head entry.
REQ-025 The head SHALL be popped on a rising edge with O_SRAM_WE=1 and I_SRAM_READY=1; it is held stable otherwise.
REQ-026 A pixel pushed at edge N SHALL appear on O_SRAM_* during cycle N+1.
REQ-027 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-028 RUN->FLUSH SHALL occur on a sampled 1->0 transition of I_FRAMESTALL; a push on that same edge is still accepted.
REQ-029 FLUSH->DONE SHALL occur when the FIFO is empty.
REQ-030 DONE SHALL assert O_FRAMEDONE for exactly one cycle, then go to IDLE.
REQ-031 O_SRAM_WE SHALL be 0 in IDLE and DONE.

Reset
REQ-032 On I_RESET=1 at a rising edge, regardless of I_LOCK:
- state=IDLE, FIFO emptied (pending pixels lost), clear counter=0;
- O_STALL=0, O_SRAM_WE=0, O_SRAM_ADDR=0, O_SRAM_DATA=0, O_FRAMEDONE=0, O_DROPCOUNT=0.
REQ-033 Reset asserted mid-CLEAR or mid-FLUSH SHALL abort without further writes or an O_FRAMEDONE pulse.

Configuration
REQ-034 Macro FB_CLEAR_EN defined: the CLEAR state and its counter are present.
REQ-035 Macro FB_CLEAR_EN undefined: CLEAR logic is removed and IDLE goes directly to RUN.

Verification
REQ-036 FB_CLEAR_EN undefined, I_SRAM_READY=1; frame start, then pushes (addr 5, 16'h1234) and (addr 6, 16'hABCD) -> writes in that order, one cycle after each push.
REQ-037 I_SRAM_READY=0, 10 consecutive pushes at FIFO_DEPTH=8 -> O_STALL=1 once count=7; no entry overwritten; all accepted pixels written in order after READY=1.
REQ-038 I_ADDR=256000 and 262143 pushed in RUN -> no write, O_DROPCOUNT=2; next frame start -> 0.
REQ-039 FB_CLEAR_EN defined, FB_PIXELS=16, READY toggling every cycle -> 16 writes of CLEAR_COLOR to 0..15, O_STALL=1 throughout, then RUN.
REQ-040 I_FRAMESTALL falls with 3 entries queued -> 3 writes, then one O_FRAMEDONE pulse, state IDLE.
REQ-041 I_RESET during FLUSH with 4 entries queued -> O_SRAM_WE=0 next cycle, no O_FRAMEDONE, all outputs 0.

Source files
------------

// File: rtl/framebuffer_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_writer_if
//  Purpose  : Rasterizer pixel stream and SRAM write port of framebuffer_writer.
//  Revision : 1.0  initial release
// ============================================================================
interface framebuffer_writer_if;
    logic        I_LOCK;
    logic        I_FRAMESTALL;
    logic        I_PIXVALID;
    logic [17:0] I_ADDR;
    logic [15:0] I_COLOR;
    logic        I_SRAM_READY;
    logic        O_STALL;
    logic [17:0] O_SRAM_ADDR;
    logic [15:0] O_SRAM_DATA;
    logic        O_SRAM_WE;
    logic        O_FRAMEDONE;
    logic [15:0] O_DROPCOUNT;

    modport slave (
        input  I_LOCK, I_FRAMESTALL, I_PIXVALID, I_ADDR, I_COLOR, I_SRAM_READY,
        output O_STALL, O_SRAM_ADDR, O_SRAM_DATA, O_SRAM_WE, O_FRAMEDONE, O_DROPCOUNT
    );

    modport master (
        output I_LOCK, I_FRAMESTALL, I_PIXVALID, I_ADDR, I_COLOR, I_SRAM_READY,
        input  O_STALL, O_SRAM_ADDR, O_SRAM_DATA, O_SRAM_WE, O_FRAMEDONE, O_DROPCOUNT
    );
endinterface
`default_nettype wire

// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
//  Module   : framebuffer_writer
//  Purpose  : Buffers rasterizer pixels in a FWFT FIFO and writes them to SRAM,
//             optionally clearing the frame first (macro FB_CLEAR_EN).
//  Revision : 1.0  initial release
// ============================================================================
module framebuffer_writer #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          FB_PIXELS   = 256000,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
    input  wire logic           I_CLOCK,
    input  wire logic           I_RESET,
    framebuffer_writer_if.slave bus
);
    localparam int                c_PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [18:0]       c_FB_LIMIT    = 19'(FB_PIXELS);
    localparam logic [c_PTR_W:0]  c_STALL_LEVEL = (c_PTR_W + 1)'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [33:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 r_fs_q;
    logic [15:0]          r_drop;

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_fifo_ne;
    logic                 w_addr_ok;
    logic [33:0]          w_head;
    logic                 w_stall;
    logic                 w_we;
    logic                 w_fifo_out;
    logic [17:0]          w_sram_addr;
    logic [15:0]          w_sram_data;
    logic                 w_framedone;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_drop_clr;

`ifdef FB_CLEAR_EN
    localparam logic [17:0] c_CLR_LAST = 18'(FB_PIXELS - 1);
    logic [17:0]          r_clr_addr;
    logic                 w_clr_last;
    assign w_clr_last = (r_clr_addr == c_CLR_LAST);
`endif

    assign w_rise    = bus.I_FRAMESTALL & ~r_fs_q;
    assign w_fall    = ~bus.I_FRAMESTALL & r_fs_q;
    assign w_fifo_ne = (r_count != '0);
    assign w_addr_ok = ({1'b0, bus.I_ADDR} < c_FB_LIMIT);
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_we         = 1'b0;
        w_fifo_out   = 1'b0;
        w_sram_addr  = '0;
        w_sram_data  = '0;
        w_framedone  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
`ifdef FB_CLEAR_EN
                    w_state_next = S_CLEAR;
`else
                    w_state_next = S_RUN;
`endif
                end
            end
`ifdef FB_CLEAR_EN
            S_CLEAR: begin
                w_stall     = 1'b1;
                w_we        = 1'b1;
                w_sram_addr = r_clr_addr;
                w_sram_data = CLEAR_COLOR;
                if (bus.I_SRAM_READY && w_clr_last) w_state_next = S_RUN;
            end
`endif
            S_RUN: begin
                w_stall    = (r_count >= c_STALL_LEVEL);
                w_fifo_out = w_fifo_ne;
                if (w_fall) w_state_next = S_FLUSH;
            end
            S_FLUSH: begin
                w_stall    = 1'b1;
                w_fifo_out = w_fifo_ne;
                if (!w_fifo_ne) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_stall      = 1'b1;
                w_framedone  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_fifo_out) begin
            w_we        = 1'b1;
            w_sram_addr = w_head[33:16];
            w_sram_data = w_head[15:0];
        end
    end

    // A stalled in-range pixel is simply not taken (the source holds it); only
    // pixels the writer actually consumes can be counted as drops.
    assign w_push     = bus.I_LOCK & (r_state == S_RUN) & bus.I_PIXVALID & ~w_stall & w_addr_ok;
    assign w_pop      = bus.I_LOCK & w_fifo_out & bus.I_SRAM_READY;
    assign w_drop     = bus.I_LOCK & bus.I_PIXVALID &
                        ((r_state == S_RUN) ? (~w_stall & ~w_addr_ok) : 1'b1);
    assign w_drop_clr = bus.I_LOCK & (r_state == S_IDLE) & w_rise;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            r_state  <= S_IDLE;
            r_fs_q   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else if (bus.I_LOCK) begin
            r_state <= w_state_next;
            r_fs_q  <= bus.I_FRAMESTALL;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop_clr)
                r_drop <= '0;
            else if (w_drop && (r_drop != 16'hFFFF))
                r_drop <= r_drop + 16'd1;
        end
    end

`ifdef FB_CLEAR_EN
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET)
            r_clr_addr <= '0;
        else if (bus.I_LOCK && (r_state == S_CLEAR) && bus.I_SRAM_READY)
            r_clr_addr <= w_clr_last ? 18'd0 : r_clr_addr + 18'd1;
    end
`endif

    always_ff @(posedge I_CLOCK) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.I_ADDR, bus.I_COLOR};
    end

    assign bus.O_STALL     = w_stall;
    assign bus.O_SRAM_WE   = w_we;
    assign bus.O_SRAM_ADDR = w_sram_addr;
    assign bus.O_SRAM_DATA = w_sram_data;
    assign bus.O_FRAMEDONE = w_framedone;
    assign bus.O_DROPCOUNT = r_drop;
endmodule
`default_nettype wire
